// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundles the pipeline-side request/handshake signals and the stall/flush
//   controls exchanged between the 5-stage pipeline and its hazard unit.
//
//   master : pipeline side. Drives the issue/decode/bus-status signals and
//            receives the stall/flush controls.
//   slave  : hazard unit side (hazard_scoreboard).
//
//   Signals
//     issue_v/issue_wen/issue_rd/issue_lat : instruction moving D->E
//     srca_d/srcb_d/usea_d/useb_d         : D-stage operand reads
//     branch_d                             : D instr needs operands in D
//     mdu_use_d/mdu_start/mdu_div          : multiply/divide unit usage
//     i_data_ok/d_data_ok                  : instruction/data bus status
//     flush_all                            : redirect, drop in-flight producers
//     stallF..flushW, mdu_busy, stall_cnt  : controls back to the pipeline
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int LAT_W = 3,
  parameter int CNT_W = 32
);
  logic             issue_v;
  logic             issue_wen;
  logic [AW-1:0]    issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic [AW-1:0]    srca_d;
  logic [AW-1:0]    srcb_d;
  logic             usea_d;
  logic             useb_d;
  logic             branch_d;
  logic             mdu_use_d;
  logic             mdu_start;
  logic             mdu_div;
  logic             i_data_ok;
  logic             d_data_ok;
  logic             flush_all;

  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushE;
  logic             flushW;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output issue_v, issue_wen, issue_rd, issue_lat,
    output srca_d, srcb_d, usea_d, useb_d, branch_d,
    output mdu_use_d, mdu_start, mdu_div,
    output i_data_ok, d_data_ok, flush_all,
    input  stallF, stallD, stallE, stallM, flushE, flushW, mdu_busy, stall_cnt
  );

  modport slave (
    input  issue_v, issue_wen, issue_rd, issue_lat,
    input  srca_d, srcb_d, usea_d, useb_d, branch_d,
    input  mdu_use_d, mdu_start, mdu_div,
    input  i_data_ok, d_data_ok, flush_all,
    output stallF, stallD, stallE, stallM, flushE, flushW, mdu_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for a 5-stage (F/D/E/M/W) pipeline. Each GPR has a small
//   countdown giving the number of cycles until its pending result becomes
//   forwardable; D-stage readers stall while that result is not yet usable.
//   A multiply/divide busy FSM stalls HI/LO consumers, bus handshakes stall
//   the front/back end, and a saturating counter records D-stall cycles.
//
//   Ports
//     clk     : clock
//     resetn  : asynchronous reset, active low
//     hz      : hazard_scoreboard_if.slave (issue, operands, MDU, bus status
//               in; stallF/D/E/M, flushE/W, mdu_busy, stall_cnt out)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int LAT_W   = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic           clk,
  input  logic           resetn,
  hazard_scoreboard_if.slave hz
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MCTR_W  = $clog2(MAX_LAT + 1);
  localparam logic [MCTR_W-1:0] DIV_LOAD = MCTR_W'(DIV_LAT - 1);
  localparam logic [MCTR_W-1:0] MUL_LOAD = MCTR_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  logic [LAT_W-1:0]  cnt_r [NREG];
  mdu_state_t        mdu_state_r;
  logic [MCTR_W-1:0] mdu_ctr_r;
  logic              mdu_busy_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic [LAT_W-1:0]  cnt_a_s;
  logic [LAT_W-1:0]  cnt_b_s;
  logic              opnd_a_s;
  logic              opnd_b_s;
  logic              raw_stall_s;
  logic              mdu_stall_s;
  logic              stall_d_s;
  logic              stall_e_s;
  logic              flush_e_s;
  logic              flush_w_s;
  logic              advance_s;
  logic              issue_hit_s;
  logic [MCTR_W-1:0] mdu_load_s;

  // Operand hazard detection from the scoreboard counts.
  always_comb begin
    cnt_a_s  = cnt_r[hz.srca_d];
    cnt_b_s  = cnt_r[hz.srcb_d];
    opnd_a_s = 1'b0;
    opnd_b_s = 1'b0;
    // A D-resolved branch cannot use the E->D forward path, so it waits
    // until the count reaches zero; other readers only wait while the
    // result is more than one cycle away.
    if (hz.usea_d && (hz.srca_d != {AW{1'b0}})) begin
      if (hz.branch_d) begin
        opnd_a_s = (cnt_a_s != {LAT_W{1'b0}});
      end else begin
        opnd_a_s = (cnt_a_s > LAT_W'(1));
      end
    end else begin
      opnd_a_s = 1'b0;
    end
    if (hz.useb_d && (hz.srcb_d != {AW{1'b0}})) begin
      if (hz.branch_d) begin
        opnd_b_s = (cnt_b_s != {LAT_W{1'b0}});
      end else begin
        opnd_b_s = (cnt_b_s > LAT_W'(1));
      end
    end else begin
      opnd_b_s = 1'b0;
    end
  end

  // Stage stall/flush equations.
  always_comb begin
    raw_stall_s = opnd_a_s | opnd_b_s;
    mdu_stall_s = hz.mdu_use_d & mdu_busy_r;
    stall_d_s   = ~hz.i_data_ok | ~hz.d_data_ok | raw_stall_s | mdu_stall_s;
    stall_e_s   = ~hz.d_data_ok;
    // A bubble is only meaningful when E actually accepts a new entry.
    flush_e_s   = stall_d_s & ~stall_e_s & ~hz.flush_all;
    flush_w_s   = ~hz.d_data_ok;
    advance_s   = ~stall_e_s;
    issue_hit_s = hz.issue_v & hz.issue_wen & (hz.issue_rd != {AW{1'b0}});
    mdu_load_s  = hz.mdu_div ? DIV_LOAD : MUL_LOAD;
  end

  // Per-register countdown scoreboard; register 0 is never tracked.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= {LAT_W{1'b0}};
      end
    end else if (hz.flush_all) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= {LAT_W{1'b0}};
      end
    end else if (advance_s) begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0) begin
          cnt_r[r] <= {LAT_W{1'b0}};
        end else if (issue_hit_s && (hz.issue_rd == AW'(r))) begin
          // A fresh producer replaces whatever count the register had.
          cnt_r[r] <= hz.issue_lat;
        end else if (cnt_r[r] != {LAT_W{1'b0}}) begin
          cnt_r[r] <= cnt_r[r] - LAT_W'(1);
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= cnt_r[r];
      end
    end
  end

  // Multiply/divide busy FSM; the counter runs regardless of pipeline stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mdu_state_r <= MDU_IDLE;
      mdu_ctr_r   <= {MCTR_W{1'b0}};
      mdu_busy_r  <= 1'b0;
    end else if (hz.flush_all) begin
      mdu_state_r <= MDU_IDLE;
      mdu_ctr_r   <= {MCTR_W{1'b0}};
      mdu_busy_r  <= 1'b0;
    end else begin
      case (mdu_state_r)
        MDU_IDLE: begin
          if (hz.mdu_start) begin
            mdu_state_r <= MDU_BUSY;
            mdu_ctr_r   <= mdu_load_s;
            mdu_busy_r  <= 1'b1;
          end else begin
            mdu_state_r <= MDU_IDLE;
            mdu_busy_r  <= 1'b0;
          end
        end
        MDU_BUSY: begin
          if (mdu_ctr_r == {MCTR_W{1'b0}}) begin
            mdu_state_r <= MDU_DONE;
            mdu_busy_r  <= 1'b0;
          end else begin
            mdu_ctr_r   <= mdu_ctr_r - MCTR_W'(1);
            mdu_busy_r  <= 1'b1;
          end
        end
        MDU_DONE: begin
          // Back-to-back MDU ops may start in the result cycle.
          if (hz.mdu_start) begin
            mdu_state_r <= MDU_BUSY;
            mdu_ctr_r   <= mdu_load_s;
            mdu_busy_r  <= 1'b1;
          end else begin
            mdu_state_r <= MDU_IDLE;
            mdu_busy_r  <= 1'b0;
          end
        end
        default: begin
          mdu_state_r <= MDU_IDLE;
          mdu_ctr_r   <= {MCTR_W{1'b0}};
          mdu_busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of D-stage stall cycles; only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_d_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.stallF    = stall_d_s;
  assign hz.stallD    = stall_d_s;
  assign hz.stallE    = stall_e_s;
  assign hz.stallM    = stall_e_s;
  assign hz.flushE    = flush_e_s;
  assign hz.flushW    = flush_w_s;
  assign hz.mdu_busy  = mdu_busy_r;
  assign hz.stall_cnt = stall_cnt_r;

  hazard_scoreboard_chk u_chk (
    .clk       (clk),
    .resetn    (resetn),
    .issue_v   (hz.issue_v),
    .stall_d   (stall_d_s),
    .mdu_start (hz.mdu_start),
    .mdu_busy  (mdu_busy_r)
  );

endmodule

// -----------------------------------------------------------------------------
// hazard_scoreboard_chk
//   Interface-usage properties of the hazard unit: the pipeline never issues
//   while D is stalled and never starts the MDU while it is busy.
//   Ports: clk, resetn, issue_v, stall_d, mdu_start, mdu_busy (all inputs).
// -----------------------------------------------------------------------------
module hazard_scoreboard_chk (
  input logic clk,
  input logic resetn,
  input logic issue_v,
  input logic stall_d,
  input logic mdu_start,
  input logic mdu_busy
);

  a_no_issue_on_stall: assert property (
    @(posedge clk) disable iff (!resetn) !(issue_v && stall_d));

  a_no_start_when_busy: assert property (
    @(posedge clk) disable iff (!resetn) !(mdu_start && mdu_busy));

endmodule
